// File: rtl/vector_lsu.sv
// Strided vector load/store unit: moves up to 2^COUNT_WIDTH-1 vectors between a
// word-addressed memory and ready/valid load/store streams. Lane data is packed
// as six 8-bit lanes in 19-bit slots; padding bits are always written/returned 0.
// Optional feature: define VECTOR_LSU_BOUNDS_CHECK_EN to suppress any access at
// an address >= MEM_SIZE, pulsing err together with done.
module vector_lsu #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned VEC_WIDTH     = 114,
  parameter int unsigned COUNT_WIDTH   = 5,
  parameter int unsigned MEM_SIZE      = 35000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // Request channel
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic                     reqWrite,
  input  logic [ADDRESS_WIDTH-1:0] reqBase,
  input  logic [ADDRESS_WIDTH-1:0] reqStride,
  input  logic [COUNT_WIDTH-1:0]   reqCount,
  // Store data stream
  input  logic                     sdValid,
  output logic                     sdReady,
  input  logic [VEC_WIDTH-1:0]     sdData,
  // Load data stream
  output logic                     ldValid,
  input  logic                     ldReady,
  output logic [VEC_WIDTH-1:0]     ldData,
  // Memory port
  output logic [ADDRESS_WIDTH-1:0] memReadAddress,
  input  logic [VEC_WIDTH-1:0]     memReadData,
  output logic                     memWriteEnable,
  output logic [ADDRESS_WIDTH-1:0] memWriteAddress,
  output logic [VEC_WIDTH-1:0]     memWriteData,
  // Status
  output logic                     done,
  output logic                     err
);

  localparam int unsigned LaneBits = 19;
  localparam int unsigned NumLanes = VEC_WIDTH / LaneBits;

  // Bits [19i+17:19i+10] of each lane slot carry data; everything else is padding.
  function automatic logic [VEC_WIDTH-1:0] build_lane_mask();
    logic [VEC_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NumLanes); i++) begin
      for (int b = 10; b <= 17; b++) begin
        m[i * LaneBits + b] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [VEC_WIDTH-1:0] LaneMask = build_lane_mask();

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] stride_q, stride_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic                     ld_valid_q, ld_valid_d;
  logic [VEC_WIDTH-1:0]     ld_data_q, ld_data_d;
  logic                     addr_oob;
  logic                     ld_can_take;

`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
  logic err_q, err_d;
  assign addr_oob = (addr_q >= ADDRESS_WIDTH'(MEM_SIZE));
  assign err      = (state_q == StDone) && err_q;
`else
  assign addr_oob = 1'b0;
  assign err      = 1'b0;
`endif

  // Output register slot is free when empty or being drained this cycle.
  assign ld_can_take = !ld_valid_q || ldReady;

  assign ldValid = ld_valid_q;
  assign ldData  = ld_data_q;
  assign done    = (state_q == StDone);

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // Next-state, handshakes and memory port drive.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    stride_d        = stride_q;
    remaining_d     = remaining_q;
    ld_valid_d      = ld_valid_q;
    ld_data_d       = ld_data_q;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
    err_d           = err_q;
`endif
    reqReady        = 1'b0;
    sdReady         = 1'b0;
    memReadAddress  = '0;
    memWriteEnable  = 1'b0;
    memWriteAddress = '0;
    memWriteData    = '0;

    unique case (state_q)
      StIdle: begin
        reqReady = 1'b1;
        if (reqValid) begin
          addr_d      = reqBase;
          stride_d    = reqStride;
          remaining_d = reqCount;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
          err_d       = 1'b0;
`endif
          if (reqCount == '0) begin
            state_d = StDone;
          end else if (reqWrite) begin
            state_d = StStore;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        // Only present an address while a fetch is still outstanding.
        if ((remaining_q != '0) && !addr_oob) begin
          memReadAddress = addr_q;
        end
        if (remaining_q != '0) begin
          if (ld_can_take) begin
            if (addr_oob) begin
              // Any held vector was just handshaken, so the slot can be dropped.
              ld_valid_d = 1'b0;
              state_d    = StDone;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
              err_d      = 1'b1;
`endif
            end else begin
              ld_data_d   = memReadData & LaneMask;
              ld_valid_d  = 1'b1;
              addr_d      = addr_q + stride_q;
              remaining_d = remaining_q - 1'b1;
            end
          end
        end else if (ld_valid_q && ldReady) begin
          ld_valid_d = 1'b0;
          state_d    = StDone;
        end
      end

      StStore: begin
        sdReady = 1'b1;
        if (sdValid) begin
          if (addr_oob) begin
            state_d = StDone;
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
            err_d   = 1'b1;
`endif
          end else begin
            memWriteEnable  = 1'b1;
            memWriteAddress = addr_q;
            memWriteData    = sdData & LaneMask;
            addr_d          = addr_q + stride_q;
            remaining_d     = remaining_q - 1'b1;
            if (remaining_q == COUNT_WIDTH'(1)) begin
              state_d = StDone;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu: behavioural memory, a negedge monitor that logs
// load handshakes, writes and done/err pulses, and hand-built expected vectors.
module tb_vector_lsu;

  localparam int AW  = 32;
  localparam int VW  = 114;
  localparam int CW  = 5;
  localparam int MEM = 35000;

  logic          clk;
  logic          rst_n;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] reqBase;
  logic [AW-1:0] reqStride;
  logic [CW-1:0] reqCount;
  logic          sdValid;
  logic          sdReady;
  logic [VW-1:0] sdData;
  logic          ldValid;
  logic          ldReady;
  logic [VW-1:0] ldData;
  logic [AW-1:0] memReadAddress;
  logic [VW-1:0] memReadData;
  logic          memWriteEnable;
  logic [AW-1:0] memWriteAddress;
  logic [VW-1:0] memWriteData;
  logic          done;
  logic          err;

  vector_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqBase        (reqBase),
    .reqStride      (reqStride),
    .reqCount       (reqCount),
    .sdValid        (sdValid),
    .sdReady        (sdReady),
    .sdData         (sdData),
    .ldValid        (ldValid),
    .ldReady        (ldReady),
    .ldData         (ldData),
    .memReadAddress (memReadAddress),
    .memReadData    (memReadData),
    .memWriteEnable (memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData   (memWriteData),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Place six lane bytes into their 19-bit slots; every other bit takes 'pad'.
  function automatic logic [VW-1:0] make_vec(input logic [47:0] lanes, input logic pad);
    logic [VW-1:0] v;
    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < 19; b++) begin
        v[19 * i + b] = (b >= 10 && b <= 17) ? lanes[8 * i + b - 10] : pad;
      end
    end
    return v;
  endfunction

  function automatic logic [47:0] lanes_of(input int a);
    logic [47:0] l;
    for (int i = 0; i < 6; i++) l[8 * i +: 8] = 8'(a + 37 * i);
    return l;
  endfunction

  function automatic logic [VW-1:0] exp_load(input int a);
    return make_vec(lanes_of(a), 1'b0);
  endfunction

  // Behavioural memory with combinational read; padding stored as all ones.
  logic [VW-1:0] mem [0:MEM-1];
  initial begin
    for (int a = 0; a < MEM; a++) mem[a] = make_vec(lanes_of(a), 1'b1);
  end
  assign memReadData = (memReadAddress < AW'(MEM)) ? mem[memReadAddress] : '0;
  always @(posedge clk) begin
    if (memWriteEnable && memWriteAddress < AW'(MEM)) mem[memWriteAddress] <= memWriteData;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, mid-cycle.
  logic [VW-1:0] ld_q[$];
  int            ld_cyc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [VW-1:0] wr_data_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            err_cnt = 0;
  int            ldv_cnt = 0;
  int            rd_oob = 0;
  logic          prev_stall = 1'b0;
  logic [VW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("ld_hold_valid", ldValid, 1'b1);
        check("ld_hold_data", ldData, prev_data);
      end
      if (ldValid) ldv_cnt++;
      if (ldValid && ldReady) begin
        ld_q.push_back(ldData);
        ld_cyc_q.push_back(cyc);
      end
      if (memWriteEnable) begin
        wr_addr_q.push_back(memWriteAddress);
        wr_data_q.push_back(memWriteData);
      end
      if (memReadAddress >= AW'(MEM)) rd_oob++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        check("err_with_done", done, 1'b1);
      end
      prev_stall = ldValid && !ldReady;
      prev_data  = ldData;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic wr, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                       input logic [CW-1:0] cnt);
    int n;
    @(posedge clk); #1;
    reqValid  = 1'b1;
    reqWrite  = wr;
    reqBase   = base;
    reqStride = stride;
    reqCount  = cnt;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!reqReady) check("req_accept", reqReady, 1'b1);
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    check("done_seen", done_cnt - start, 1);
  endtask

  initial begin
    int d0, l0, w0, v0, e0;
    logic [3:0] pat;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqBase = '0; reqStride = '0;
    reqCount = '0; sdValid = 1'b0; sdData = '0; ldReady = 1'b0;
    #23;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_reqReady", reqReady, 1'b1);
    check("rst_ldValid", ldValid, 1'b0);
    check("rst_ldData", ldData, '0);
    check("rst_sdReady", sdReady, 1'b0);
    check("rst_memWE", memWriteEnable, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdaddr", memReadAddress, '0);
    check("rst_wraddr", memWriteAddress, '0);

    // Unit-stride load at full throughput
    ldReady = 1'b1;
    d0 = done_cnt; l0 = ld_q.size();
    issue(1'b0, 100, 1, 3);
    wait_done(d0);
    check("ld3_count", ld_q.size() - l0, 3);
    for (int k = 0; k < 3; k++) check($sformatf("ld3_data%0d", k), ld_q[l0 + k], exp_load(100 + k));
    check("ld3_consec1", ld_cyc_q[l0 + 1] - ld_cyc_q[l0], 1);
    check("ld3_consec2", ld_cyc_q[l0 + 2] - ld_cyc_q[l0 + 1], 1);
    check("ld3_done_cycle", done_cyc - ld_cyc_q[l0 + 2], 1);
    @(negedge clk); #2;
    check("ld3_done_one_cycle", done_cnt - d0, 1);

    // Strided store; padding in the source must not reach memory
    sdValid = 1'b1;
    sdData  = make_vec({6{8'hAA}}, 1'b1);
    d0 = done_cnt; w0 = wr_addr_q.size();
    issue(1'b1, 10, 2, 2);
    wait_done(d0);
    sdValid = 1'b0;
    check("st2_count", wr_addr_q.size() - w0, 2);
    check("st2_addr0", wr_addr_q[w0], 10);
    check("st2_addr1", wr_addr_q[w0 + 1], 12);
    check("st2_data0", wr_data_q[w0], make_vec({6{8'hAA}}, 1'b0));
    check("st2_data1", wr_data_q[w0 + 1], make_vec({6{8'hAA}}, 1'b0));
    check("st2_mem11_untouched", mem[11], make_vec(lanes_of(11), 1'b1));

    // Back-pressured load: ldReady cycles 1,0,0,1
    pat = 4'b1001;
    d0 = done_cnt; l0 = ld_q.size();
    issue(1'b0, 200, 1, 4);
    for (int k = 0; k < 80 && done_cnt == d0; k++) begin
      ldReady = pat[k % 4];
      @(posedge clk); #1;
    end
    ldReady = 1'b1;
    wait_done(d0);
    check("ld4_count", ld_q.size() - l0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("ld4_data%0d", k), ld_q[l0 + k], exp_load(200 + k));

    // Zero-length request: done only, no memory traffic
    d0 = done_cnt; w0 = wr_addr_q.size(); v0 = ldv_cnt;
    issue(1'b1, 500, 1, 0);
    wait_done(d0);
    check("z_writes", wr_addr_q.size() - w0, 0);
    d0 = done_cnt;
    issue(1'b0, 500, 1, 0);
    wait_done(d0);
    check("z_ldvalid", ldv_cnt - v0, 0);

    // Stride 0 repeats one address
    d0 = done_cnt; l0 = ld_q.size();
    issue(1'b0, 50, 0, 2);
    wait_done(d0);
    check("s0_count", ld_q.size() - l0, 2);
    check("s0_data0", ld_q[l0], exp_load(50));
    check("s0_data1", ld_q[l0 + 1], exp_load(50));

    // A request offered while busy is ignored
    d0 = done_cnt; w0 = wr_addr_q.size();
    issue(1'b1, 400, 1, 2);
    for (int k = 0; k < 3; k++) begin
      reqValid = 1'b1; reqWrite = 1'b0; reqBase = 999; reqCount = 1;
      @(negedge clk);
      check("busy_reqReady", reqReady, 1'b0);
      @(posedge clk); #1;
    end
    reqValid = 1'b0;
    sdValid = 1'b1;
    sdData  = make_vec(48'h0102_0304_0506, 1'b0);
    wait_done(d0);
    sdValid = 1'b0;
    check("busy_writes", wr_addr_q.size() - w0, 2);
    check("busy_addr0", wr_addr_q[w0], 400);
    check("busy_addr1", wr_addr_q[w0 + 1], 401);

`ifndef VECTOR_LSU_BOUNDS_CHECK_EN
    // Address arithmetic wraps
    d0 = done_cnt; w0 = wr_addr_q.size();
    sdValid = 1'b1;
    issue(1'b1, 32'hFFFF_FFFE, 3, 2);
    wait_done(d0);
    sdValid = 1'b0;
    check("wrap_addr0", wr_addr_q[w0], 32'hFFFF_FFFE);
    check("wrap_addr1", wr_addr_q[w0 + 1], 32'h0000_0001);
`else
    // Out-of-range load: one vector, then err with done, no access at MEM_SIZE
    d0 = done_cnt; l0 = ld_q.size(); e0 = err_cnt;
    issue(1'b0, 34999, 1, 2);
    wait_done(d0);
    check("oob_ld_count", ld_q.size() - l0, 1);
    check("oob_ld_data", ld_q[l0], exp_load(34999));
    check("oob_ld_err", err_cnt - e0, 1);
    // Out-of-range store: write suppressed
    d0 = done_cnt; w0 = wr_addr_q.size(); e0 = err_cnt;
    sdValid = 1'b1;
    issue(1'b1, 35000, 1, 1);
    wait_done(d0);
    sdValid = 1'b0;
    check("oob_st_writes", wr_addr_q.size() - w0, 0);
    check("oob_st_err", err_cnt - e0, 1);
`endif

    // Reset during beat 2 of a 4-beat store
    d0 = done_cnt; w0 = wr_addr_q.size();
    sdValid = 1'b1;
    sdData  = make_vec({6{8'h55}}, 1'b0);
    issue(1'b1, 300, 1, 4);
    for (int k = 0; k < 50 && wr_addr_q.size() == w0; k++) begin
      @(negedge clk); #2;
    end
    check("rst_beat1_seen", wr_addr_q.size() - w0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_memWE", memWriteEnable, 1'b0);
    check("midrst_sdReady", sdReady, 1'b0);
    check("midrst_reqReady", reqReady, 1'b1);
    check("midrst_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sdValid = 1'b0;
    check("midrst_writes", wr_addr_q.size() - w0, 1);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_mem301", mem[301], make_vec(lanes_of(301), 1'b1));

    // Global invariants
    check("no_rd_oob", rd_oob, 0);
`ifdef VECTOR_LSU_BOUNDS_CHECK_EN
    check("err_total", err_cnt, 2);
`else
    check("err_total", err_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
